// File: rtl/tricolor_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tricolor_sweep_ctrl_if
// Purpose  : Bundles the board-side and comparator-side signals of the
//            tricolor sweep controller.
// Modports : master - the controller (drives operands, LEDs, counters, status)
//            slave  - the board/comparator side (drives requests and results)
// Signals  : start, mode, a_in[1:0], b_in[1:0]      job request
//            a_out[1:0], b_out[1:0]                 operands to comparator
//            red_in, green_in, blue_in              comparator result
//            led_r, led_g, led_b                    registered last result
//            red_cnt, green_cnt, blue_cnt [CNT_W]   outcome tallies
//            busy, done, err                        status
// Revision : 1.0 - initial release
// ============================================================================
interface tricolor_sweep_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             mode;
  logic [1:0]       a_in;
  logic [1:0]       b_in;
  logic [1:0]       a_out;
  logic [1:0]       b_out;
  logic             red_in;
  logic             green_in;
  logic             blue_in;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, mode, a_in, b_in, red_in, green_in, blue_in,
    output a_out, b_out, led_r, led_g, led_b,
           red_cnt, green_cnt, blue_cnt, busy, done, err
  );

  modport slave (
    output start, mode, a_in, b_in, red_in, green_in, blue_in,
    input  a_out, b_out, led_r, led_g, led_b,
           red_cnt, green_cnt, blue_cnt, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/tricolor_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tricolor_sweep_ctrl
// Purpose  : Sequencer for the tricolor 2-bit magnitude comparator. Runs a
//            sweep of all 16 operand pairs or a single user pair, holds each
//            pair HOLD_CYCLES cycles, registers the colour onto the LEDs and
//            tallies red (a>b) / green (a==b) / blue (a<b) outcomes.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous active-high reset
//            bus   - tricolor_sweep_ctrl_if.master (request, operands,
//                    comparator results, LEDs, counters, busy/done/err)
// Params   : HOLD_CYCLES (>=1) cycles per operand pair
//            CNT_W (>=5) outcome counter width
// Options  : TRICOLOR_SWEEP_CHECK_EN - when defined, a sticky err flag is set
//            if the comparator result is not the expected one-hot colour.
//            Undefined: err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tricolor_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 5
) (
  input  wire logic            clk,
  input  wire logic            reset,
  tricolor_sweep_ctrl_if.master bus
);

  // Hold counter needs at least one bit even when HOLD_CYCLES == 1.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] c_HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [3:0]       r_idx;
  logic [HC_W-1:0]  r_hold;
  logic             r_led_r;
  logic             r_led_g;
  logic             r_led_b;
  logic [CNT_W-1:0] r_red_cnt;
  logic [CNT_W-1:0] r_green_cnt;
  logic [CNT_W-1:0] r_blue_cnt;
  logic             r_busy;
  logic             r_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef TRICOLOR_SWEEP_CHECK_EN
  logic       r_err;
  logic [2:0] w_exp;
  // Expected colour for the operands currently on the comparator.
  assign w_exp = {(r_idx[3:2] > r_idx[1:0]),
                  (r_idx[3:2] == r_idx[1:0]),
                  (r_idx[3:2] < r_idx[1:0])};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_idx       <= 4'd0;
      r_hold      <= '0;
      r_led_r     <= 1'b0;
      r_led_g     <= 1'b0;
      r_led_b     <= 1'b0;
      r_red_cnt   <= '0;
      r_green_cnt <= '0;
      r_blue_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef TRICOLOR_SWEEP_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_red_cnt   <= '0;
            r_green_cnt <= '0;
            r_blue_cnt  <= '0;
            r_hold      <= '0;
            r_idx       <= bus.mode ? {bus.a_in, bus.b_in} : 4'd0;
            r_busy      <= 1'b1;
            r_state     <= S_DRIVE;
`ifdef TRICOLOR_SWEEP_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          if (r_hold == c_HOLD_LAST) begin
            r_led_r <= bus.red_in;
            r_led_g <= bus.green_in;
            r_led_b <= bus.blue_in;
            if (bus.red_in)   r_red_cnt   <= sat_inc(r_red_cnt);
            if (bus.green_in) r_green_cnt <= sat_inc(r_green_cnt);
            if (bus.blue_in)  r_blue_cnt  <= sat_inc(r_blue_cnt);
`ifdef TRICOLOR_SWEEP_CHECK_EN
            if ({bus.red_in, bus.green_in, bus.blue_in} != w_exp) r_err <= 1'b1;
`endif
            r_hold <= '0;
            // Single-pair jobs and the last sweep pair finish here; idx
            // never wraps back to 0.
            if (r_mode || (r_idx == 4'hF)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_hold <= r_hold + HC_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_out     = r_idx[3:2];
  assign bus.b_out     = r_idx[1:0];
  assign bus.led_r     = r_led_r;
  assign bus.led_g     = r_led_g;
  assign bus.led_b     = r_led_b;
  assign bus.red_cnt   = r_red_cnt;
  assign bus.green_cnt = r_green_cnt;
  assign bus.blue_cnt  = r_blue_cnt;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
`ifdef TRICOLOR_SWEEP_CHECK_EN
  assign bus.err       = r_err;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tricolor_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tricolor_sweep_ctrl
// Purpose  : Directed bench for tricolor_sweep_ctrl. DUT A uses HOLD_CYCLES=4,
//            DUT B uses HOLD_CYCLES=1. Each DUT sees a behavioural tricolor
//            comparator; DUT A's blue result can be forced high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tricolor_sweep_ctrl;

`ifdef TRICOLOR_SWEEP_CHECK_EN
  localparam bit c_CHECK_EN = 1'b1;
`else
  localparam bit c_CHECK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic inject_blue;
  int   checks;
  int   errors;

  tricolor_sweep_ctrl_if #(.CNT_W(5)) ifA ();
  tricolor_sweep_ctrl_if #(.CNT_W(5)) ifB ();

  tricolor_sweep_ctrl #(.HOLD_CYCLES(4), .CNT_W(5)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.master)
  );

  tricolor_sweep_ctrl #(.HOLD_CYCLES(1), .CNT_W(5)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.master)
  );

  // Behavioural tricolor comparators.
  assign ifA.red_in   = (ifA.a_out > ifA.b_out);
  assign ifA.green_in = (ifA.a_out == ifA.b_out);
  assign ifA.blue_in  = (ifA.a_out < ifA.b_out) | inject_blue;
  assign ifB.red_in   = (ifB.a_out > ifB.b_out);
  assign ifB.green_in = (ifB.a_out == ifB.b_out);
  assign ifB.blue_in  = (ifB.a_out < ifB.b_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until done is seen on the selected DUT; reports edges taken and
  // the number of observed busy cycles.
  task automatic wait_done(input bit sel_b, input int bound, output int ticks, output int busy_n);
    ticks  = 0;
    busy_n = 0;
    while (((sel_b ? ifB.done : ifA.done) !== 1'b1) && (ticks < bound)) begin
      if ((sel_b ? ifB.busy : ifA.busy) === 1'b1) busy_n++;
      tick();
      ticks++;
    end
    chk("done_seen", {31'd0, (sel_b ? ifB.done : ifA.done)}, 32'd1);
  endtask

  int t;
  int nb;
  int done_seen;

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    inject_blue = 1'b0;
    ifA.start = 1'b0; ifA.mode = 1'b0; ifA.a_in = 2'd0; ifA.b_in = 2'd0;
    ifB.start = 1'b0; ifB.mode = 1'b0; ifB.a_in = 2'd0; ifB.b_in = 2'd0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    chk("rst_a_out", ifA.a_out, 0);
    chk("rst_b_out", ifA.b_out, 0);
    chk("rst_leds", {ifA.led_r, ifA.led_g, ifA.led_b}, 0);
    chk("rst_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, 0);
    chk("rst_busy_done_err", {ifA.busy, ifA.done, ifA.err}, 0);
    chk("rst_b_busy", ifB.busy, 0);

    // ---- sweep, HOLD_CYCLES=4 ----
    ifA.mode = 1'b0; ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    chk("sw_busy_start", ifA.busy, 1);
    chk("sw_a0", {ifA.a_out, ifA.b_out}, 0);
    wait_done(1'b0, 200, t, nb);
    chk("sw_latency", t, 64);
    chk("sw_busy_cycles", nb, 64);
    chk("sw_busy_at_done", ifA.busy, 0);
    chk("sw_red", ifA.red_cnt, 6);
    chk("sw_green", ifA.green_cnt, 4);
    chk("sw_blue", ifA.blue_cnt, 6);
    chk("sw_ab", {ifA.a_out, ifA.b_out}, 4'hF);
    chk("sw_leds", {ifA.led_r, ifA.led_g, ifA.led_b}, 3'b010);
    chk("sw_err", ifA.err, 0);
    tick();
    chk("sw_done_pulse", ifA.done, 0);
    chk("sw_hold_cnt", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd6, 5'd4, 5'd6});

    // ---- start ignored during DRIVE and DONE ----
    ifA.mode = 1'b0; ifA.start = 1'b1;
    tick();
    wait_done(1'b0, 200, t, nb);   // start held high throughout
    chk("si_latency", t, 64);
    chk("si_busy_cycles", nb, 64);
    chk("si_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd6, 5'd4, 5'd6});
    tick();                         // DONE edge with start still high
    ifA.start = 1'b0;
    chk("si_no_restart", {ifA.busy, ifA.done}, 0);
    tick();
    chk("si_idle", ifA.busy, 0);

    // ---- single pair a=2, b=1 ----
    ifA.mode = 1'b1; ifA.a_in = 2'b10; ifA.b_in = 2'b01; ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    chk("sp_ab", {ifA.a_out, ifA.b_out}, 4'b1001);
    wait_done(1'b0, 50, t, nb);
    chk("sp_latency", t, 4);
    chk("sp_busy_cycles", nb, 4);
    chk("sp_ab_hold", {ifA.a_out, ifA.b_out}, 4'b1001);
    chk("sp_leds", {ifA.led_r, ifA.led_g, ifA.led_b}, 3'b100);
    chk("sp_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd1, 5'd0, 5'd0});
    tick();

    // ---- checker: blue forced while a=2, b=1 ----
    inject_blue = 1'b1;
    ifA.mode = 1'b1; ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    wait_done(1'b0, 50, t, nb);
    chk("ck_leds", {ifA.led_r, ifA.led_g, ifA.led_b}, 3'b101);
    chk("ck_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd1, 5'd0, 5'd1});
    chk("ck_err", ifA.err, {31'd0, c_CHECK_EN});
    inject_blue = 1'b0;
    tick(); tick(); tick();
    chk("ck_err_sticky", ifA.err, {31'd0, c_CHECK_EN});

    // ---- mid-job reset at 20th busy cycle ----
    ifA.mode = 1'b0; ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    chk("mr_err_cleared", ifA.err, 0);
    for (int i = 1; i < 20; i++) tick();
    chk("mr_busy", ifA.busy, 1);
    chk("mr_ab", {ifA.a_out, ifA.b_out}, 4'b0100);
    chk("mr_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd0, 5'd1, 5'd3});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_ab0", {ifA.a_out, ifA.b_out}, 0);
    chk("mr_leds0", {ifA.led_r, ifA.led_g, ifA.led_b}, 0);
    chk("mr_cnts0", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, 0);
    chk("mr_status0", {ifA.busy, ifA.done, ifA.err}, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ifA.done !== 1'b0 || ifA.busy !== 1'b0) done_seen++;
    end
    chk("mr_stays_idle", done_seen, 0);
    ifA.mode = 1'b0; ifA.start = 1'b1;
    tick();
    ifA.start = 1'b0;
    wait_done(1'b0, 200, t, nb);
    chk("mr_resweep_latency", t, 64);
    chk("mr_resweep_cnts", {ifA.red_cnt, ifA.green_cnt, ifA.blue_cnt}, {5'd6, 5'd4, 5'd6});

    // ---- sweep, HOLD_CYCLES=1 ----
    ifB.mode = 1'b0; ifB.start = 1'b1;
    tick();
    ifB.start = 1'b0;
    wait_done(1'b1, 100, t, nb);
    chk("h1_latency", t, 16);
    chk("h1_busy_cycles", nb, 16);
    chk("h1_cnts", {ifB.red_cnt, ifB.green_cnt, ifB.blue_cnt}, {5'd6, 5'd4, 5'd6});
    chk("h1_ab", {ifB.a_out, ifB.b_out}, 4'hF);
    chk("h1_err", ifB.err, 0);
    tick();
    chk("h1_done_pulse", ifB.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
